// File: rtl/ex_issue_stage.sv
// ex_issue_stage: ID/EX register with ALU control decode, operand forwarding and valid/ready handshake
module ex_issue_stage #(
    parameter int XLEN = 32,
    parameter int RIDX = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_rs_val,
    input  logic [XLEN-1:0] in_rt_val,
    input  logic [XLEN-1:0] in_imm,
    input  logic [RIDX-1:0] in_rs_idx,
    input  logic [RIDX-1:0] in_rt_idx,
    input  logic [RIDX-1:0] in_rd_idx,
    input  logic [1:0]      in_alu_op,
    input  logic [5:0]      in_funct,
    input  logic            in_alu_src,
    input  logic            in_reg_write,
    input  logic            flush,
    input  logic            exmem_reg_write,
    input  logic [RIDX-1:0] exmem_rd,
    input  logic [XLEN-1:0] exmem_result,
    input  logic            memwb_reg_write,
    input  logic [RIDX-1:0] memwb_rd,
    input  logic [XLEN-1:0] memwb_result,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_control,
    output logic [RIDX-1:0] out_rd,
    output logic            out_reg_write,
    output logic            illegal_op
);
    logic            valid;
    logic [XLEN-1:0] rs_q, rt_q, imm_q, fwd_rs, fwd_rt;
    logic [RIDX-1:0] rs_idx_q, rt_idx_q, rd_q;
    logic            src_q, rw_q, ill_q, dec_ill, accept;
    logic [3:0]      ctl_q, dec_ctl;

    // Newest in-flight producer wins; r0 and idle cycles never forward
    function automatic logic [XLEN-1:0] fwd(input logic [RIDX-1:0] idx, input logic [XLEN-1:0] val);
        return (valid && idx != '0 && exmem_reg_write && exmem_rd == idx) ? exmem_result :
               (valid && idx != '0 && memwb_reg_write && memwb_rd == idx) ? memwb_result : val;
    endfunction

    assign in_ready      = ~valid | out_ready | flush;
    assign accept        = in_valid & in_ready & ~flush;
    assign out_valid     = valid;
    assign fwd_rs        = fwd(rs_idx_q, rs_q);
    assign fwd_rt        = fwd(rt_idx_q, rt_q);
    assign alu_a         = fwd_rs;
    assign alu_b         = src_q ? imm_q : fwd_rt;
    assign alu_control   = ctl_q;
    assign out_rd        = rd_q;
    assign out_reg_write = valid & rw_q;
    assign illegal_op    = valid & ill_q;

    // ALU control decode of the incoming instruction, latched at capture
    always_comb begin
        dec_ill = 1'b0;
        dec_ctl = 4'b0010;
        case (in_alu_op)
            2'b01: dec_ctl = 4'b0110;
            2'b10:
                case (in_funct)
                    6'b100000: dec_ctl = 4'b0010;
                    6'b100010: dec_ctl = 4'b0110;
                    6'b100100: dec_ctl = 4'b0000;
                    6'b100101: dec_ctl = 4'b0001;
                    6'b101010: dec_ctl = 4'b0111;
                    6'b100111: dec_ctl = 4'b1100;
                    default:   dec_ill = 1'b1;
                endcase
            2'b11: dec_ill = 1'b1;
            default: ;
        endcase
    end

    // Pipeline register: reset > flush > capture > drain > stall refresh of forwarded operands
    always_ff @(posedge clk) begin
        if (reset) begin
            valid    <= 1'b0;
            rs_q     <= '0;
            rt_q     <= '0;
            imm_q    <= '0;
            rs_idx_q <= '0;
            rt_idx_q <= '0;
            rd_q     <= '0;
            src_q    <= 1'b0;
            rw_q     <= 1'b0;
            ill_q    <= 1'b0;
            ctl_q    <= 4'b0010;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (accept) begin
            valid    <= 1'b1;
            rs_q     <= in_rs_val;
            rt_q     <= in_rt_val;
            imm_q    <= in_imm;
            rs_idx_q <= in_rs_idx;
            rt_idx_q <= in_rt_idx;
            rd_q     <= in_rd_idx;
            src_q    <= in_alu_src;
            rw_q     <= in_reg_write;
            ill_q    <= dec_ill;
            ctl_q    <= dec_ctl;
        end else if (valid && out_ready) begin
            valid <= 1'b0;
        end else if (valid) begin
            rs_q <= fwd_rs;
            rt_q <= fwd_rt;
        end
    end
endmodule

// File: tb/tb_ex_issue_stage.sv
// tb_ex_issue_stage: randomized check of ex_issue_stage against a behavioural model plus directed literal checks
module tb_ex_issue_stage;
    logic        clk = 0, reset = 1, in_valid = 0, in_ready, in_alu_src = 0, in_reg_write = 0, flush = 0;
    logic [31:0] in_rs_val = 0, in_rt_val = 0, in_imm = 0, exmem_result = 0, memwb_result = 0, alu_a, alu_b;
    logic [4:0]  in_rs_idx = 0, in_rt_idx = 0, in_rd_idx = 0, exmem_rd = 0, memwb_rd = 0, out_rd;
    logic [1:0]  in_alu_op = 0;
    logic [5:0]  in_funct = 0;
    logic        exmem_reg_write = 0, memwb_reg_write = 0, out_valid, out_ready = 0, out_reg_write, illegal_op;
    logic [3:0]  alu_control;
    int checks = 0, errors = 0;

    ex_issue_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs_val(in_rs_val), .in_rt_val(in_rt_val), .in_imm(in_imm),
        .in_rs_idx(in_rs_idx), .in_rt_idx(in_rt_idx), .in_rd_idx(in_rd_idx),
        .in_alu_op(in_alu_op), .in_funct(in_funct), .in_alu_src(in_alu_src), .in_reg_write(in_reg_write),
        .flush(flush), .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .out_valid(out_valid), .out_ready(out_ready), .alu_a(alu_a), .alu_b(alu_b),
        .alu_control(alu_control), .out_rd(out_rd), .out_reg_write(out_reg_write), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rs_val, rt_val, imm;
        logic [4:0]  rs_idx, rt_idx, rd;
        logic [1:0]  op;
        logic [5:0]  funct;
        logic        src, rw;
    } ins_t;

    ins_t        h = '0;
    bit          mv = 0, armed = 0;
    logic [31:0] ea, ert, eb;
    logic [4:0]  ed;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", n, act, exp, $time);
        end
    endtask

    // Returns {illegal, control} from the ALUOp/funct tables
    function automatic logic [4:0] dec(input logic [1:0] op, input logic [5:0] f);
        logic [5:0] ft [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27};
        logic [3:0] ct [6] = '{4'd2, 4'd6, 4'd0, 4'd1, 4'd7, 4'd12};
        if (op == 2'd0) return 5'b0_0010;
        if (op == 2'd1) return 5'b0_0110;
        if (op == 2'd3) return 5'b1_0010;
        for (int i = 0; i < 6; i++) if (ft[i] == f) return {1'b0, ct[i]};
        return 5'b1_0010;
    endfunction

    function automatic logic [31:0] mfwd(input logic [4:0] idx, input logic [31:0] val);
        if (!mv || idx == 0) return val;
        if (exmem_reg_write && exmem_rd == idx) return exmem_result;
        if (memwb_reg_write && memwb_rd == idx) return memwb_result;
        return val;
    endfunction

    // Compare against the model, then advance the model with the inputs the next edge will see
    always @(negedge clk) begin
        ea  = mfwd(h.rs_idx, h.rs_val);
        ert = mfwd(h.rt_idx, h.rt_val);
        eb  = h.src ? h.imm : ert;
        ed  = dec(h.op, h.funct);
        if (armed) begin
            chk("out_valid", out_valid, mv);
            chk("in_ready", in_ready, !mv || out_ready || flush);
            chk("alu_a", alu_a, ea);
            chk("alu_b", alu_b, eb);
            chk("alu_control", alu_control, ed[3:0]);
            chk("out_rd", out_rd, h.rd);
            chk("out_reg_write", out_reg_write, mv && h.rw);
            chk("illegal_op", illegal_op, mv && ed[4]);
        end
        if (reset) begin
            h = '0; mv = 0; armed = 1;
        end else if (flush) begin
            mv = 0;
        end else if (in_valid && (!mv || out_ready)) begin
            h = '{in_rs_val, in_rt_val, in_imm, in_rs_idx, in_rt_idx, in_rd_idx,
                  in_alu_op, in_funct, in_alu_src, in_reg_write};
            mv = 1;
        end else if (mv && out_ready) begin
            mv = 0;
        end else if (mv) begin
            h.rs_val = ea;
            h.rt_val = ert;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [4:0] rsi, input logic [31:0] rsv, input logic [4:0] rti,
                         input logic [31:0] rtv, input logic [4:0] rd, input logic [1:0] op,
                         input logic [5:0] f);
        in_valid = 1; in_rs_idx = rsi; in_rs_val = rsv; in_rt_idx = rti; in_rt_val = rtv;
        in_rd_idx = rd; in_alu_op = op; in_funct = f; in_alu_src = 0; in_reg_write = 1; in_imm = 32'h1234;
    endtask

    initial begin
        step(); step();
        reset = 0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_alu_control", alu_control, 4'b0010);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        step();
        chk("idle_out_valid", out_valid, 0);

        out_ready = 1;
        offer(1, 9, 2, 4, 5, 2'b10, 6'b100010);
        step(); in_valid = 0;
        chk("sub_out_valid", out_valid, 1);
        chk("sub_alu_control", alu_control, 4'b0110);
        chk("sub_alu_a", alu_a, 9);
        chk("sub_alu_b", alu_b, 4);

        offer(3, 1, 3, 2, 5, 2'b00, 0);
        step(); in_valid = 0;
        exmem_reg_write = 1; exmem_rd = 3; exmem_result = 32'hAA;
        memwb_reg_write = 1; memwb_rd = 3; memwb_result = 32'hBB;
        #1;
        chk("fwd_prio_a", alu_a, 32'hAA);
        chk("fwd_prio_b", alu_b, 32'hAA);
        exmem_reg_write = 0; memwb_reg_write = 0;
        offer(0, 7, 0, 8, 5, 2'b00, 0);
        step(); in_valid = 0;
        exmem_reg_write = 1; exmem_rd = 0; memwb_reg_write = 1; memwb_rd = 0;
        #1;
        chk("r0_a", alu_a, 7);
        chk("r0_b", alu_b, 8);
        exmem_reg_write = 0; memwb_reg_write = 0;

        offer(4, 32'h11, 6, 32'h22, 7, 2'b00, 0);
        step(); in_valid = 0; out_ready = 0;
        memwb_reg_write = 1; memwb_rd = 4; memwb_result = 32'h55;
        #1;
        chk("stall1_a", alu_a, 32'h55);
        chk("stall1_in_ready", in_ready, 0);
        step(); memwb_reg_write = 0; #1;
        chk("stall2_a", alu_a, 32'h55);
        chk("stall2_in_ready", in_ready, 0);
        step();
        chk("stall3_a", alu_a, 32'h55);
        chk("stall3_in_ready", in_ready, 0);

        flush = 1;
        offer(1, 1, 1, 1, 9, 2'b00, 0);
        #1;
        chk("flush_in_ready", in_ready, 1);
        step(); flush = 0; in_valid = 0;
        chk("flush_out_valid", out_valid, 0);
        step();
        chk("flush_dropped", out_valid, 0);

        out_ready = 1;
        offer(1, 1, 2, 2, 8, 2'b10, 6'b111111);
        step();
        chk("ill_alu_control", alu_control, 4'b0010);
        chk("ill_illegal_op", illegal_op, 1);
        for (int i = 10; i < 13; i++) begin
            offer(1, i, 2, i, 5'(i), 2'b01, 0);
            step();
            chk("b2b_out_valid", out_valid, 1);
            chk("b2b_out_rd", out_rd, i);
        end
        in_valid = 0;

        for (int n = 0; n < 3000; n++) begin
            logic [5:0] ft [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27};
            reset = ($urandom_range(0, 199) == 0);
            flush = ($urandom_range(0, 9) == 0);
            in_valid = $urandom_range(0, 2) != 0;
            out_ready = $urandom_range(0, 4) < 3;
            in_rs_idx = 5'($urandom_range(0, 3)); in_rt_idx = 5'($urandom_range(0, 3));
            in_rd_idx = 5'($urandom); in_rs_val = $urandom; in_rt_val = $urandom; in_imm = $urandom;
            in_alu_op = 2'($urandom); in_alu_src = 1'($urandom); in_reg_write = 1'($urandom);
            in_funct = ($urandom_range(0, 3) != 0) ? ft[$urandom_range(0, 5)] : 6'($urandom);
            exmem_reg_write = 1'($urandom); exmem_rd = 5'($urandom_range(0, 3)); exmem_result = $urandom;
            memwb_reg_write = 1'($urandom); memwb_rd = 5'($urandom_range(0, 3)); memwb_result = $urandom;
            step();
        end
        reset = 0; flush = 0; in_valid = 0;
        step(); step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
